// File: rtl/segment_frame_reader.sv
// rtl/segment_frame_reader.sv - per-frame segment snapshot with LCD persistence and 2-cycle lookup
//
// Ports:
//   clk, reset_n      single clock, asynchronous active-low reset
//   segments          live segment array [x][y] of one-hot Z bits from the normalizer
//   vsync             frame sync; its rising edge schedules one snapshot/decay update
//   req_valid/blank/x/y/z   per-pixel lookup request from the mask renderer
//   resp_valid/on/level     registered response, two edges after the request

module segment_frame_reader #(
    parameter int MAX_X_SEGMENT = 9,
    parameter int MAX_Y_SEGMENT = 16,
    parameter int MAX_Z_SEGMENT = 4,
    parameter int DECAY_ENABLE  = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [MAX_Z_SEGMENT-1:0] segments [MAX_X_SEGMENT][MAX_Y_SEGMENT],
    input  logic                     vsync,
    input  logic                     req_valid,
    input  logic                     req_blank,
    input  logic [3:0]               req_x,
    input  logic [3:0]               req_y,
    input  logic [1:0]               req_z,
    output logic                     resp_valid,
    output logic                     resp_on,
    output logic [1:0]               resp_level
);

    logic                          vsync_d;
    logic                          armed;
    logic                          update_pending;

    logic [MAX_Z_SEGMENT-1:0]      shadow [MAX_X_SEGMENT][MAX_Y_SEGMENT];
    logic [MAX_Z_SEGMENT-1:0][1:0] level  [MAX_X_SEGMENT][MAX_Y_SEGMENT];

    logic                          s1_valid;
    logic                          s1_blank;
    logic [3:0]                    s1_x;
    logic [3:0]                    s1_y;
    logic [1:0]                    s1_z;

    logic                          rd_on;
    logic [1:0]                    rd_level;

    function automatic logic [1:0] next_level(input logic seg_on, input logic [1:0] cur);
        if (seg_on) begin
            return 2'd3;
        end else if (DECAY_ENABLE != 0) begin
            return (cur == 2'd0) ? 2'd0 : cur - 2'd1;
        end else begin
            return 2'd0;
        end
    endfunction

    // Edge detect. armed stays low for the first sampled cycle after reset so
    // that a vsync already high at release is not mistaken for a new frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vsync_d        <= 1'b0;
            armed          <= 1'b0;
            update_pending <= 1'b0;
        end else begin
            vsync_d        <= vsync;
            armed          <= 1'b1;
            update_pending <= vsync & ~vsync_d & armed;
        end
    end

    // Whole-array update in a single cycle; outside it the live array is ignored,
    // which keeps a frame's output tear-free while the normalizer keeps writing.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int xi = 0; xi < MAX_X_SEGMENT; xi++) begin
                for (int yi = 0; yi < MAX_Y_SEGMENT; yi++) begin
                    shadow[xi][yi] <= '0;
                    level[xi][yi]  <= '0;
                end
            end
        end else if (update_pending) begin
            for (int xi = 0; xi < MAX_X_SEGMENT; xi++) begin
                for (int yi = 0; yi < MAX_Y_SEGMENT; yi++) begin
                    shadow[xi][yi] <= segments[xi][yi];
                    for (int zi = 0; zi < MAX_Z_SEGMENT; zi++) begin
                        level[xi][yi][zi] <= next_level(segments[xi][yi][zi], level[xi][yi][zi]);
                    end
                end
            end
        end
    end

    // Stage 1: register the request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_blank <= 1'b0;
            s1_x     <= '0;
            s1_y     <= '0;
            s1_z     <= '0;
        end else begin
            s1_valid <= req_valid;
            s1_blank <= req_blank;
            s1_x     <= req_x;
            s1_y     <= req_y;
            s1_z     <= req_z;
        end
    end

    // Address match over the real array extent; an out-of-range address simply
    // matches nothing and reads as off/level 0.
    always_comb begin
        rd_on    = 1'b0;
        rd_level = 2'd0;
        for (int xi = 0; xi < MAX_X_SEGMENT; xi++) begin
            for (int yi = 0; yi < MAX_Y_SEGMENT; yi++) begin
                for (int zi = 0; zi < MAX_Z_SEGMENT; zi++) begin
                    if (int'(s1_x) == xi && int'(s1_y) == yi && int'(s1_z) == zi) begin
                        rd_on    = shadow[xi][yi][zi];
                        rd_level = level[xi][yi][zi];
                    end
                end
            end
        end
    end

    // Stage 2: registered response. Reading here on the update edge naturally
    // returns the pre-update contents.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            resp_valid <= 1'b0;
            resp_on    <= 1'b0;
            resp_level <= 2'd0;
        end else begin
            resp_valid <= s1_valid;
            resp_on    <= s1_valid & ~s1_blank & rd_on;
            resp_level <= (s1_valid && !s1_blank) ? rd_level : 2'd0;
        end
    end

endmodule

// File: tb/tb_segment_frame_reader.sv
// tb/tb_segment_frame_reader.sv - scoreboard bench for segment_frame_reader

module tb_segment_frame_reader;

    localparam int NX = 9;
    localparam int NY = 16;
    localparam int NZ = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [NZ-1:0] seg [NX][NY];
    logic          vsync = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_blank = 1'b0;
    logic [3:0]    req_x = '0;
    logic [3:0]    req_y = '0;
    logic [1:0]    req_z = '0;
    logic          resp_valid;
    logic          resp_on;
    logic [1:0]    resp_level;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit toggle_en = 1'b0;

    logic       m_sh [NX][NY][NZ];
    logic [1:0] m_lv [NX][NY][NZ];

    typedef struct {
        int on;
        int lvl;
        int due;
    } exp_t;

    exp_t  sb[$];
    string tag_q[$];

    segment_frame_reader #(
        .MAX_X_SEGMENT(NX),
        .MAX_Y_SEGMENT(NY),
        .MAX_Z_SEGMENT(NZ),
        .DECAY_ENABLE (1)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .segments  (seg),
        .vsync     (vsync),
        .req_valid (req_valid),
        .req_blank (req_blank),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_z     (req_z),
        .resp_valid(resp_valid),
        .resp_on   (resp_on),
        .resp_level(resp_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Every response is matched against the oldest outstanding expectation,
    // including the exact cycle it must appear on.
    always @(negedge clk) begin
        if (resp_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_resp", 1, 0);
            end else begin
                exp_t  e;
                string t;
                e = sb.pop_front();
                t = tag_q.pop_front();
                check({t, "_cycle"}, cyc, e.due);
                check({t, "_on"}, int'(resp_on), e.on);
                check({t, "_level"}, int'(resp_level), e.lvl);
            end
        end else begin
            check("idle_outputs_zero", int'({resp_on, resp_level}), 0);
        end
    end

    task automatic model_clear();
        for (int x = 0; x < NX; x++)
            for (int y = 0; y < NY; y++)
                for (int z = 0; z < NZ; z++) begin
                    m_sh[x][y][z] = 1'b0;
                    m_lv[x][y][z] = 2'd0;
                end
    endtask

    task automatic model_update();
        for (int x = 0; x < NX; x++)
            for (int y = 0; y < NY; y++)
                for (int z = 0; z < NZ; z++) begin
                    m_sh[x][y][z] = seg[x][y][z];
                    if (seg[x][y][z]) m_lv[x][y][z] = 2'd3;
                    else if (m_lv[x][y][z] != 2'd0) m_lv[x][y][z] = m_lv[x][y][z] - 2'd1;
                end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_blank = 1'b0;
        if (toggle_en) seg[2][5][3] = ~seg[2][5][3];
    endtask

    task automatic drive_req(input int x, input int y, input int z, input bit blank);
        req_valid = 1'b1;
        req_blank = blank;
        req_x     = x[3:0];
        req_y     = y[3:0];
        req_z     = z[1:0];
    endtask

    task automatic issue_exp(input string tag, input int x, input int y, input int z,
                             input bit blank, input int on, input int lvl);
        exp_t e;
        drive_req(x, y, z, blank);
        e.on  = on;
        e.lvl = lvl;
        e.due = cyc + 2;
        sb.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic issue(input string tag, input int x, input int y, input int z, input bit blank);
        int on;
        int lvl;
        on  = 0;
        lvl = 0;
        if (!blank && x < NX && y < NY && z < NZ) begin
            on  = int'(m_sh[x][y][z]);
            lvl = int'(m_lv[x][y][z]);
        end
        issue_exp(tag, x, y, z, blank, on, lvl);
    endtask

    // vsync rises in one cycle; the snapshot is taken of the array held during
    // the next cycle, so requests issued from then on see the new frame.
    task automatic frame();
        tick();
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        model_update();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int x = 0; x < NX; x++)
            for (int y = 0; y < NY; y++)
                seg[x][y] = '0;
        model_clear();

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("reset_resp_valid", int'(resp_valid), 0);
        check("reset_resp_on", int'(resp_on), 0);
        check("reset_resp_level", int'(resp_level), 0);

        // Release with vsync already high: must not count as a frame edge
        seg[0][0] = 4'b0001;
        vsync     = 1'b1;
        reset_n   = 1'b1;
        repeat (3) tick();
        issue_exp("no_edge_000", 0, 0, 0, 0, 0, 0);
        tick();
        vsync = 1'b0;
        tick();

        // First real update
        frame();
        issue_exp("first_update_000", 0, 0, 0, 0, 1, 3);

        // Decay: first pulse held high for several cycles, still one update
        tick();
        seg[0][0] = '0;
        tick();
        vsync = 1'b1;
        tick();
        model_update();
        repeat (3) tick();
        vsync = 1'b0;
        tick();
        issue_exp("decay_1", 0, 0, 0, 0, 0, 2);
        frame();
        issue_exp("decay_2", 0, 0, 0, 0, 0, 1);
        frame();
        issue_exp("decay_3", 0, 0, 0, 0, 0, 0);
        frame();
        issue_exp("decay_4_saturate", 0, 0, 0, 0, 0, 0);

        // Tear-free: bit toggles every cycle, lookups hold the sampled value
        toggle_en = 1'b1;
        repeat (2) begin
            repeat (3) tick();
            frame();
            issue("tear_253", 2, 5, 3, 0);
            for (int i = 0; i < 6; i++) begin
                tick();
                issue("tear_253", 2, 5, 3, 0);
            end
        end
        toggle_en = 1'b0;

        // Boundary addresses
        tick();
        seg[0][15] = 4'b1000;
        frame();
        issue_exp("oob_x9", 9, 0, 0, 0, 0, 0);
        tick();
        issue_exp("edge_0_15_3", 0, 15, 3, 0, 1, 3);
        tick();
        issue_exp("blank_0_15_3", 0, 15, 3, 1, 0, 0);
        tick();
        issue_exp("oob_x15", 15, 15, 3, 0, 0, 0);

        // Collision: request reaches S2 on the update edge
        tick();
        seg[4][4] = 4'b0100;
        tick();
        vsync = 1'b1;
        issue_exp("collision_old", 4, 4, 2, 0, 0, 0);
        tick();
        vsync = 1'b0;
        model_update();
        issue_exp("collision_new", 4, 4, 2, 0, 1, 3);

        // Streaming against the model
        tick();
        for (int x = 0; x < NX; x++)
            for (int y = 0; y < NY; y++)
                seg[x][y] = 4'($urandom);
        frame();
        for (int i = 0; i < 100; i++) begin
            tick();
            issue("stream", int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
        end
        for (int i = 0; i < 60; i++) begin
            tick();
            if ($urandom_range(0, 1) == 1)
                issue("gappy", int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                      int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
            if (i == 30) begin
                #2;
                reset_n = 1'b0;
                #1;
                check("midreset_resp_valid", int'(resp_valid), 0);
                check("midreset_resp_on", int'(resp_on), 0);
                check("midreset_resp_level", int'(resp_level), 0);
                sb.delete();
                tag_q.delete();
                model_clear();
                req_valid = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                reset_n = 1'b1;
            end
        end

        repeat (5) tick();
        check("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
